// File: rtl/sipo_deserializer.sv
// -----------------------------------------------------------------------------
// sipo_deserializer
//
// Serial-in / parallel-out receiver at the far end of a PISO shift-register
// link. One bit is sampled on each cycle where Valid_I is high. Every WIDTH
// samples form a word. A completed word goes into a one-entry output buffer
// that the consumer drains with a valid/ready handshake. If a word completes
// while the buffer still holds an unconsumed word, the new word is dropped and
// Overrun_O pulses for one cycle.
//
// Parameters
//   WIDTH      word width in bits (>= 2)
//   MSB_FIRST  1: the first received bit lands in Parallel_Out[WIDTH-1]
//              0: the first received bit lands in Parallel_Out[0]
//
// Ports
//   Clk           in   1      rising-edge clock
//   Rst           in   1      asynchronous reset, active-high
//   Serial_In     in   1      serial data, sampled only when Valid_I=1
//   Valid_I       in   1      bit strobe from the transmitter
//   Clear         in   1      synchronous abort of the partial word
//   Out_Ready     in   1      consumer takes Parallel_Out this cycle
//   Parallel_Out  out  WIDTH  buffered word, stable while Out_Valid=1
//   Out_Valid     out  1      output buffer holds an unconsumed word
//   Empty_Flag    out  1      inverse of Out_Valid
//   Busy_O        out  1      a partial word is in progress
//   Overrun_O     out  1      one-cycle pulse: a completed word was dropped
// -----------------------------------------------------------------------------
module sipo_deserializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Serial_In,
  input  logic             Valid_I,
  input  logic             Clear,
  input  logic             Out_Ready,
  output logic [WIDTH-1:0] Parallel_Out,
  output logic             Out_Valid,
  output logic             Empty_Flag,
  output logic             Busy_O,
  output logic             Overrun_O
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  // Collect FSM: IDLE means no bits of the current word have been received.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic             valid_q, valid_d;
  logic             busy_q,  busy_d;
  logic             overrun_q, overrun_d;

  logic             sample;     // a bit is accepted this cycle
  logic             complete;   // this sample finishes a word
  logic [WIDTH-1:0] word;       // shift register combined with the incoming bit
  logic             consume;    // buffered word is taken this cycle
  logic             load;       // completed word enters the buffer

  // Clear wins over Valid_I: a bit strobed in the same cycle is discarded.
  assign sample = Valid_I & ~Clear;

  // Incoming bit merged with the bits already collected. The shift register
  // starts each word at zero, so the unfilled positions read as zero.
  always_comb begin
    if (MSB_FIRST) begin
      word = {shift_q[WIDTH-2:0], Serial_In};
    end else begin
      word = {Serial_In, shift_q[WIDTH-1:1]};
    end
  end

  // ---------------------------------------------------------------------------
  // Collect FSM: next state, shift register and bit count
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can leave
    // it unassigned and infer a latch.
    state_d  = state_q;
    shift_d  = shift_q;
    count_d  = count_q;
    complete = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (sample) begin
          shift_d = word;
          count_d = CNT_W'(1);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (sample) begin
          if (count_q == LAST_BIT) begin
            // Word finished: the assembled value leaves through 'word'
            // and the collector starts over from an empty register.
            complete = 1'b1;
            shift_d  = '0;
            count_d  = '0;
            state_d  = ST_IDLE;
          end else begin
            shift_d = word;
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      default: begin
        shift_d = '0;
        count_d = '0;
        state_d = ST_IDLE;
      end
    endcase

    if (Clear) begin
      shift_d = '0;
      count_d = '0;
      state_d = ST_IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // One-entry output buffer with valid/ready handshake
  // ---------------------------------------------------------------------------
  assign consume = valid_q & Out_Ready;

  // A completing word may enter when the buffer is empty or is being drained
  // in the same cycle; otherwise it is dropped and reported as an overrun.
  assign load = complete & (~valid_q | Out_Ready);

  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = complete & valid_q & ~Out_Ready;

    if (load) begin
      data_d  = word;
      valid_d = 1'b1;
    end else if (consume) begin
      valid_d = 1'b0;
    end

    busy_d = (count_d != '0);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  // NOTE: reset clears every register here, including the data buffer, because
  // the consumer must see Parallel_Out=0 immediately after reset.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      count_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      count_q   <= count_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign Parallel_Out = data_q;
  assign Out_Valid    = valid_q;
  assign Empty_Flag   = ~valid_q;
  assign Busy_O       = busy_q;
  assign Overrun_O    = overrun_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// -----------------------------------------------------------------------------
// tb_sipo_deserializer
//
// Drives two deserializers from the same inputs, one MSB-first and one
// LSB-first. A small queue-based reference model predicts the outputs. The
// bench runs a table of vectors, some hand-written corner sequences, and then
// a randomized run that is checked against the model.
// -----------------------------------------------------------------------------
module tb_sipo_deserializer;

  localparam int W = 4;

  logic         Clk = 1'b0;
  logic         Rst;
  logic         Serial_In, Valid_I, Clear, Out_Ready;
  logic [W-1:0] po_msb, po_lsb;
  logic         ov_msb, ov_lsb, em_msb, em_lsb;
  logic         busy_msb, busy_lsb, ovr_msb, ovr_lsb;

  always #5 Clk = ~Clk;

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .Clk(Clk), .Rst(Rst), .Serial_In(Serial_In), .Valid_I(Valid_I),
    .Clear(Clear), .Out_Ready(Out_Ready), .Parallel_Out(po_msb),
    .Out_Valid(ov_msb), .Empty_Flag(em_msb), .Busy_O(busy_msb),
    .Overrun_O(ovr_msb)
  );

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .Clk(Clk), .Rst(Rst), .Serial_In(Serial_In), .Valid_I(Valid_I),
    .Clear(Clear), .Out_Ready(Out_Ready), .Parallel_Out(po_lsb),
    .Out_Valid(ov_lsb), .Empty_Flag(em_lsb), .Busy_O(busy_lsb),
    .Overrun_O(ovr_lsb)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: bits collected in a queue, word built by arithmetic.
  // ---------------------------------------------------------------------------
  bit           m_bits[$];
  logic [W-1:0] m_data_msb, m_data_lsb;
  logic         m_valid, m_ovr;

  task automatic model_reset();
    m_bits.delete();
    m_data_msb = '0;
    m_data_lsb = '0;
    m_valid    = 1'b0;
    m_ovr      = 1'b0;
  endtask

  task automatic model_step(input logic sin, vi, clr, rdy);
    int  wm, wl;
    bit  loaded;
    bit  consumed;
    loaded   = 1'b0;
    consumed = m_valid && rdy;
    m_ovr    = 1'b0;
    if (clr) begin
      m_bits.delete();
    end else if (vi) begin
      m_bits.push_back(sin);
      if (m_bits.size() == W) begin
        wm = 0;
        wl = 0;
        for (int i = 0; i < W; i++) begin
          wm += int'(m_bits[i]) * (1 << (W - 1 - i));
          wl += int'(m_bits[i]) * (1 << i);
        end
        m_bits.delete();
        if (!m_valid || rdy) begin
          m_data_msb = W'(wm);
          m_data_lsb = W'(wl);
          m_valid    = 1'b1;
          loaded     = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end
    end
    if (consumed && !loaded) m_valid = 1'b0;
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".valid"},   32'(ov_msb),   32'(m_valid));
    check({tag, ".valid_l"}, 32'(ov_lsb),   32'(m_valid));
    check({tag, ".empty"},   32'(em_msb),   32'(!m_valid));
    check({tag, ".busy"},    32'(busy_msb), 32'(m_bits.size() != 0));
    check({tag, ".busy_l"},  32'(busy_lsb), 32'(m_bits.size() != 0));
    check({tag, ".ovr"},     32'(ovr_msb),  32'(m_ovr));
    check({tag, ".ovr_l"},   32'(ovr_lsb),  32'(m_ovr));
    if (m_valid) begin
      check({tag, ".data_m"}, 32'(po_msb), 32'(m_data_msb));
      check({tag, ".data_l"}, 32'(po_lsb), 32'(m_data_lsb));
    end
  endtask

  // Apply one cycle of inputs, advance the model across the edge, compare.
  task automatic step(input string tag, input logic sin, vi, clr, rdy);
    Serial_In = sin;
    Valid_I   = vi;
    Clear     = clr;
    Out_Ready = rdy;
    @(posedge Clk);
    model_step(sin, vi, clr, rdy);
    #1;
    compare_model(tag);
  endtask

  task automatic send_word(input string tag, input logic [W-1:0] bits_msb_order,
                           input logic rdy);
    for (int i = W - 1; i >= 0; i--) step(tag, bits_msb_order[i], 1'b1, 1'b0, rdy);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".po_m"},  32'(po_msb),   32'(0));
    check({tag, ".po_l"},  32'(po_lsb),   32'(0));
    check({tag, ".valid"}, 32'(ov_msb),   32'(0));
    check({tag, ".empty"}, 32'(em_msb),   32'(1));
    check({tag, ".busy"},  32'(busy_msb), 32'(0));
    check({tag, ".ovr"},   32'(ovr_msb),  32'(0));
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic         sin, vi, clr, rdy;
    logic [W-1:0] msb, lsb;
    logic         valid, busy, ovr;
  } vec_t;

  vec_t tbl[14];

  initial begin
    // Bits 1,1,0,0 with a ready consumer, then a Clear that beats Valid_I,
    // then 1,0,1,0 held in the buffer and finally drained.
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'hC, 4'h3, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'hC, 4'h3, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'hA, 4'h5, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'hA, 4'h5, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'hA, 4'h5, 1'b0, 1'b0, 1'b0};

    Serial_In = 1'b0;
    Valid_I   = 1'b0;
    Clear     = 1'b0;
    Out_Ready = 1'b0;

    // Reset state
    Rst = 1'b1;
    model_reset();
    #1;
    check_reset_values("por");
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b0;

    // Table vectors
    for (int i = 0; i < 14; i++) begin
      step($sformatf("tbl%0d", i), tbl[i].sin, tbl[i].vi, tbl[i].clr, tbl[i].rdy);
      check($sformatf("tbl%0d.valid", i), 32'(ov_msb),   32'(tbl[i].valid));
      check($sformatf("tbl%0d.busy", i),  32'(busy_msb), 32'(tbl[i].busy));
      check($sformatf("tbl%0d.ovr", i),   32'(ovr_msb),  32'(tbl[i].ovr));
      if (tbl[i].valid) begin
        check($sformatf("tbl%0d.msb", i), 32'(po_msb), 32'(tbl[i].msb));
        check($sformatf("tbl%0d.lsb", i), 32'(po_lsb), 32'(tbl[i].lsb));
      end
    end

    // Asynchronous reset mid-word while the buffer holds a word
    send_word("t1fill", 4'h6, 1'b0);
    step("t1b0", 1'b1, 1'b1, 1'b0, 1'b0);
    step("t1b1", 1'b1, 1'b1, 1'b0, 1'b0);
    check("t1.pre_valid", 32'(ov_msb), 32'(1));
    #2;
    Rst = 1'b1;
    #1;
    check_reset_values("t1.async");
    model_reset();
    @(negedge Clk);
    Rst = 1'b0;

    // Bits 1,0,0,1 with gaps of 0..3 idle cycles; busy throughout
    step("t3b0", 1'b1, 1'b1, 1'b0, 1'b1);
    check("t3.busy0", 32'(busy_msb), 32'(1));
    step("t3b1", 1'b0, 1'b1, 1'b0, 1'b1);
    step("t3g1", 1'b1, 1'b0, 1'b0, 1'b1);
    check("t3.busyg", 32'(busy_msb), 32'(1));
    step("t3b2", 1'b0, 1'b1, 1'b0, 1'b1);
    for (int g = 0; g < 3; g++) step("t3g3", 1'b1, 1'b0, 1'b0, 1'b1);
    check("t3.busyg3", 32'(busy_msb), 32'(1));
    step("t3b3", 1'b1, 1'b1, 1'b0, 1'b1);
    check("t3.data", 32'(po_msb), 32'(4'h9));
    check("t3.valid", 32'(ov_msb), 32'(1));
    check("t3.busy_end", 32'(busy_msb), 32'(0));
    step("t3drain", 1'b0, 1'b0, 1'b0, 1'b1);

    // Overrun: A then 5 back-to-back with no ready consumer
    send_word("t4a", 4'hA, 1'b0);
    check("t4.dataA", 32'(po_msb), 32'(4'hA));
    send_word("t4b", 4'h5, 1'b0);
    check("t4.ovr", 32'(ovr_msb), 32'(1));
    check("t4.keepA", 32'(po_msb), 32'(4'hA));
    step("t4idle", 1'b0, 1'b0, 1'b0, 1'b0);
    check("t4.ovr_pulse", 32'(ovr_msb), 32'(0));
    check("t4.stillA", 32'(po_msb), 32'(4'hA));
    step("t4drain", 1'b0, 1'b0, 1'b0, 1'b1);
    check("t4.drained", 32'(ov_msb), 32'(0));

    // Completion in the same cycle the buffered word is consumed
    send_word("t5a", 4'h9, 1'b0);
    step("t5b0", 1'b1, 1'b1, 1'b0, 1'b0);
    step("t5b1", 1'b0, 1'b1, 1'b0, 1'b0);
    step("t5b2", 1'b1, 1'b1, 1'b0, 1'b0);
    check("t5.hold9", 32'(po_msb), 32'(4'h9));
    step("t5b3", 1'b0, 1'b1, 1'b0, 1'b1);
    check("t5.dataA", 32'(po_msb), 32'(4'hA));
    check("t5.valid", 32'(ov_msb), 32'(1));
    check("t5.no_ovr", 32'(ovr_msb), 32'(0));
    step("t5drain", 1'b0, 1'b0, 1'b0, 1'b1);

    // Randomized run against the model
    for (int n = 0; n < 4000; n++) begin
      step("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 2) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
